// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus iterative shift-add
// multiply and restoring divide, behind a valid/ready handshake on both sides.
module alu_mc #(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic [4:0]   flags
);

    localparam logic [4:0] OP_NOT  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_DEC4 = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_NOR  = 5'd7;
    localparam logic [4:0] OP_INC4 = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_SHR  = 5'd10;
    localparam logic [4:0] OP_SRA  = 5'd11;
    localparam logic [4:0] OP_SLT  = 5'd12;
    localparam logic [4:0] OP_SGT  = 5'd13;
    localparam logic [4:0] OP_SHH  = 5'd14;
    localparam logic [4:0] OP_POPC = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17;
    localparam logic [4:0] OP_REMU = 5'd18;

    localparam logic [N-1:0] FOUR = {{(N-3){1'b0}}, 3'b100};
    localparam logic [CW:0]  LAST = (CW+1)'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          accept_s;
    logic          finish_s;

    logic          in_ready_r;
    logic          out_valid_r;
    logic [N-1:0]  result_r;
    logic [N-1:0]  result_hi_r;
    logic [4:0]    flags_r;

    logic [4:0]    op_r;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  work_hi_r;
    logic [N-1:0]  work_lo_r;
    logic [CW:0]   cnt_r;

    logic [CW-1:0] sh_s;
    logic [N:0]    add_s;
    logic [N:0]    sub_s;
    logic [N:0]    inc_s;
    logic [N:0]    dec_s;
    logic [N-1:0]  alu_res_s;
    logic          alu_carry_s;
    logic          alu_ovf_s;
    logic          alu_illegal_s;
    logic          multi_s;

    logic [N:0]    mul_sum_s;
    logic [N:0]    div_sh_s;
    logic [N-1:0]  div_diff_s;
    logic          div_ge_s;
    logic [N-1:0]  iter_hi_s;
    logic [N-1:0]  iter_lo_s;
    logic          fin_dz_s;
    logic [N-1:0]  fin_res_s;
    logic [N-1:0]  fin_hi_s;

    function automatic logic [N-1:0] popcount(input logic [N-1:0] v);
        logic [N-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{(N-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic is_multi(input logic [4:0] o);
        return (o == OP_MUL) || (o == OP_DIVU) || (o == OP_REMU);
    endfunction

    assign sh_s          = b[CW-1:0];
    assign add_s         = {1'b0, a} + {1'b0, b};
    assign sub_s         = {1'b0, a} - {1'b0, b};
    assign inc_s         = {1'b0, a} + {1'b0, FOUR};
    assign dec_s         = {1'b0, a} - {1'b0, FOUR};
    assign alu_illegal_s = (op > OP_REMU);
    assign multi_s       = is_multi(op);

    // Single-cycle result, carry/borrow and signed overflow from the live inputs
    always_comb begin
        alu_res_s   = '0;
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (op)
            OP_NOT:  alu_res_s = ~a;
            OP_ADD: begin
                alu_res_s   = add_s[N-1:0];
                alu_carry_s = add_s[N];
                alu_ovf_s   = (a[N-1] == b[N-1]) && (add_s[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_res_s   = sub_s[N-1:0];
                alu_carry_s = sub_s[N];
                alu_ovf_s   = (a[N-1] != b[N-1]) && (sub_s[N-1] != a[N-1]);
            end
            OP_DEC4: begin
                alu_res_s   = dec_s[N-1:0];
                alu_carry_s = dec_s[N];
                alu_ovf_s   = (a[N-1] != FOUR[N-1]) && (dec_s[N-1] != a[N-1]);
            end
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_NOR:  alu_res_s = ~(a | b);
            OP_INC4: begin
                alu_res_s   = inc_s[N-1:0];
                alu_carry_s = inc_s[N];
                alu_ovf_s   = (a[N-1] == FOUR[N-1]) && (inc_s[N-1] != a[N-1]);
            end
            OP_SHL:  alu_res_s = a << sh_s;
            OP_SHR:  alu_res_s = a >> sh_s;
            OP_SRA:  alu_res_s = $signed(a) >>> sh_s;
            OP_SLT:  alu_res_s = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SGT:  alu_res_s = {{(N-1){1'b0}}, ($signed(a) > $signed(b))};
            OP_SHH:  alu_res_s = a << (N / 2);
            OP_POPC: alu_res_s = popcount(a);
            default: alu_res_s = '0;
        endcase
    end

    // One multiply or divide step; the final step also forms the outputs
    always_comb begin
        mul_sum_s  = work_lo_r[0] ? ({1'b0, work_hi_r} + {1'b0, a_r}) : {1'b0, work_hi_r};
        div_sh_s   = {work_hi_r, work_lo_r[N-1]};
        div_ge_s   = (div_sh_s >= {1'b0, b_r});
        div_diff_s = div_sh_s[N-1:0] - b_r;
        if (op_r == OP_MUL) begin
            iter_hi_s = mul_sum_s[N:1];
            iter_lo_s = {mul_sum_s[0], work_lo_r[N-1:1]};
        end else begin
            iter_hi_s = div_ge_s ? div_diff_s : div_sh_s[N-1:0];
            iter_lo_s = {work_lo_r[N-2:0], div_ge_s};
        end
        fin_dz_s = (op_r != OP_MUL) && (b_r == '0);
        case (op_r)
            OP_MUL: begin
                fin_res_s = iter_lo_s;
                fin_hi_s  = iter_hi_s;
            end
            OP_DIVU: begin
                fin_res_s = fin_dz_s ? '1 : iter_lo_s;
                fin_hi_s  = '0;
            end
            OP_REMU: begin
                fin_res_s = fin_dz_s ? a_r : iter_hi_s;
                fin_hi_s  = '0;
            end
            default: begin
                fin_res_s = '0;
                fin_hi_s  = '0;
            end
        endcase
    end

    // Next-state logic: accept in IDLE, count N steps in BUSY, hold in DONE
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = multi_s ? BUSY : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == LAST) begin
                    finish_s     = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            result_hi_r <= '0;
            flags_r     <= 5'b00000;
            op_r        <= 5'd0;
            a_r         <= '0;
            b_r         <= '0;
            work_hi_r   <= '0;
            work_lo_r   <= '0;
            cnt_r       <= '0;
        end else begin
            in_ready_r <= (state_next_s == IDLE);
            if (accept_s) begin
                op_r      <= op;
                a_r       <= a;
                b_r       <= b;
                cnt_r     <= '0;
                work_hi_r <= '0;
                work_lo_r <= (op == OP_MUL) ? b : a;
                if (!multi_s) begin
                    result_r    <= alu_res_s;
                    result_hi_r <= '0;
                    flags_r     <= {alu_illegal_s, 1'b0, alu_ovf_s, alu_carry_s, (alu_res_s == '0)};
                    out_valid_r <= 1'b1;
                end
            end else if (state_r == BUSY) begin
                work_hi_r <= iter_hi_s;
                work_lo_r <= iter_lo_s;
                cnt_r     <= cnt_r + {{CW{1'b0}}, 1'b1};
                if (finish_s) begin
                    result_r    <= fin_res_s;
                    result_hi_r <= fin_hi_s;
                    flags_r     <= {1'b0, fin_dz_s, 1'b0, 1'b0, (fin_res_s == '0)};
                    out_valid_r <= 1'b1;
                end
            end else if ((state_r == DONE) && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign flags     = flags_r;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed cases with literal expectations, then randomized
// traffic checked every cycle against a behavioural reference model.
module tb_alu_mc;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] h;
        logic [4:0]  f;
    } exp_t;

    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic [4:0]  flags;

    int checks = 0;
    int failures = 0;

    logic m_init = 1'b0;
    logic m_ready;
    logic m_valid;
    int   m_wait;
    exp_t m_out;
    exp_t m_pend;

    alu_mc #(.N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t ref_model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      sr;
        logic [63:0] w;
        int          sh;
        e  = '0;
        sh = int'(y[4:0]);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            5'd0: e.r = ~x;
            5'd1: begin
                w = {32'd0, x} + {32'd0, y}; e.r = w[31:0]; e.f[1] = w[32];
                sr = sx + sy; e.f[2] = (sr > SMAX) || (sr < SMIN);
            end
            5'd2: begin
                e.r = x - y; e.f[1] = (x < y);
                sr = sx - sy; e.f[2] = (sr > SMAX) || (sr < SMIN);
            end
            5'd3: begin
                e.r = x - 32'd4; e.f[1] = (x < 32'd4);
                sr = sx - 64'sd4; e.f[2] = (sr > SMAX) || (sr < SMIN);
            end
            5'd4: e.r = x & y;
            5'd5: e.r = x | y;
            5'd6: e.r = x ^ y;
            5'd7: e.r = ~(x | y);
            5'd8: begin
                w = {32'd0, x} + 64'd4; e.r = w[31:0]; e.f[1] = w[32];
                sr = sx + 64'sd4; e.f[2] = (sr > SMAX) || (sr < SMIN);
            end
            5'd9:  e.r = x << sh;
            5'd10: e.r = x >> sh;
            5'd11: e.r = 32'($signed(x) >>> sh);
            5'd12: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd13: e.r = ($signed(x) > $signed(y)) ? 32'd1 : 32'd0;
            5'd14: e.r = x << 16;
            5'd15: e.r = 32'($countones(x));
            5'd16: begin
                w = {32'd0, x} * {32'd0, y}; e.r = w[31:0]; e.h = w[63:32];
            end
            5'd17: begin
                if (y == 32'd0) begin e.r = 32'hFFFF_FFFF; e.f[3] = 1'b1; end
                else e.r = x / y;
            end
            5'd18: begin
                if (y == 32'd0) begin e.r = x; e.f[3] = 1'b1; end
                else e.r = x % y;
            end
            default: e.f[4] = 1'b1;
        endcase
        e.f[0] = (e.r == 32'd0);
        return e;
    endfunction

    // Reference model: tracks handshake timing and the expected outputs
    always @(posedge clk) begin
        if (rst) begin
            m_init  <= 1'b1;
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_wait  <= 0;
            m_out   <= '0;
        end else if (m_init) begin
            if (m_ready && in_valid) begin
                m_ready <= 1'b0;
                if (op inside {5'd16, 5'd17, 5'd18}) begin
                    m_wait <= 32;
                    m_pend <= ref_model(op, a, b);
                end else begin
                    m_valid <= 1'b1;
                    m_out   <= ref_model(op, a, b);
                end
            end else if (m_wait > 0) begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) begin
                    m_valid <= 1'b1;
                    m_out   <= m_pend;
                end
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
                m_ready <= 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_init) begin
            check("mon_in_ready", 64'(in_ready), 64'(m_ready));
            check("mon_out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                check("mon_result", 64'(result), 64'(m_out.r));
                check("mon_result_hi", 64'(result_hi), 64'(m_out.h));
                check("mon_flags", 64'(flags), 64'(m_out.f));
            end
        end
    end

    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic [31:0] r, output logic [31:0] h,
                          output logic [4:0] f);
        int g;
        op = o; a = x; b = y; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin step(); g++; end
        if (g >= 100) check("accept_timeout", 64'd1, 64'd0);
        step();
        in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin step(); lat++; end
        if (!out_valid) check("result_timeout", 64'd1, 64'd0);
        r = result; h = result_hi; f = flags;
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          g;
        int          seen;
        logic [31:0] r;
        logic [31:0] h;
        logic [4:0]  f;
        int          sel;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 5'd0; a = 32'd0; b = 32'd0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_result_hi", 64'(result_hi), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        run_op(5'd1, 32'h7FFF_FFFF, 32'd1, lat, r, h, f);
        check("add_lat", 64'(lat), 64'd1);
        check("add_res", 64'(r), 64'h8000_0000);
        check("add_flags", 64'(f), 64'b00100);

        run_op(5'd2, 32'd3, 32'd5, lat, r, h, f);
        check("sub_res", 64'(r), 64'hFFFF_FFFE);
        check("sub_flags", 64'(f), 64'b00010);

        run_op(5'd16, 32'hFFFF_FFFF, 32'd2, lat, r, h, f);
        check("mul_lat", 64'(lat), 64'd33);
        check("mul_lo", 64'(r), 64'hFFFF_FFFE);
        check("mul_hi", 64'(h), 64'd1);
        check("mul_flags", 64'(f), 64'd0);

        run_op(5'd17, 32'd123, 32'd0, lat, r, h, f);
        check("divz_lat", 64'(lat), 64'd33);
        check("divz_res", 64'(r), 64'hFFFF_FFFF);
        check("divz_flags", 64'(f), 64'b01000);

        run_op(5'd18, 32'd100, 32'd7, lat, r, h, f);
        check("remu_res", 64'(r), 64'd2);
        check("remu_flags", 64'(f), 64'd0);

        run_op(5'd9, 32'd1, 32'hFFFF_FFE4, lat, r, h, f);
        check("shl_upper_b_ignored", 64'(r), 64'd16);

        run_op(5'd15, 32'hF0F0_F0F1, 32'd0, lat, r, h, f);
        check("popcount", 64'(r), 64'd17);

        // backpressure with new requests held during DONE
        out_ready = 1'b0; op = 5'd6; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin step(); g++; end
        step();
        op = 5'd1; a = 32'd10; b = 32'd20;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_hold_result", 64'(result), 64'h0FF0_0FF0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_ready_after_hs", 64'(in_ready), 64'd1);
        check("bp_valid_after_hs", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        check("bp_new_valid", 64'(out_valid), 64'd1);
        check("bp_new_result", 64'(result), 64'd30);
        step();

        // reset in the middle of a multiply
        op = 5'd16; a = 32'd5; b = 32'd7; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin step(); g++; end
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("abort_no_pulse", 64'(seen), 64'd0);

        run_op(5'd20, 32'h1234_5678, 32'h9ABC_DEF0, lat, r, h, f);
        check("ill_lat", 64'(lat), 64'd1);
        check("ill_res", 64'(r), 64'd0);
        check("ill_hi", 64'(h), 64'd0);
        check("ill_flags", 64'(f), 64'b10001);

        // randomized traffic, checked by the monitor against the model
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 249) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            sel      = $urandom_range(0, 9);
            if (sel == 0) op = 5'($urandom_range(16, 18));
            else          op = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0:       a = 32'h7FFF_FFFF;
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'($urandom_range(0, 3));
                1:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
